operand_fetch: RTL and testbench

- Read-side initiator for the register file: accepts a decoded MIPS instruction word, drives the two regfile read addresses, and captures the two source operands into output registers.
- Captured operands are presented to the execute stage over a valid/ready handshake.
- Observes the regfile write port so that a write landing in the fetch cycle is forwarded, not lost.
- Sits between the instruction register and the ALU operand registers in the multicycle datapath.

---
 rtl/operand_fetch_pkg.sv | 18 +
 rtl/operand_fwd_mux.sv | 22 ++
 rtl/operand_fetch.sv | 104 ++++++++++
 tb/tb_operand_fetch.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared types and instruction field positions for the operand fetch block.
package operand_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;

endpackage

// File: rtl/operand_fwd_mux.sv
// Per-operand source select: hardwired zero register, same-edge writeback, or regfile read.
module operand_fwd_mux #(
  parameter int width     = 32,
  parameter int addrWidth = 5
) (
  input  logic [addrWidth-1:0] i_srcAddr,
  input  logic                 i_wbWe,
  input  logic [addrWidth-1:0] i_wbAddr,
  input  logic [width-1:0]     i_wbData,
  input  logic [width-1:0]     i_rfData,
  output logic [width-1:0]     o_operand
);

  always_comb begin
    o_operand = i_rfData;
    if (i_srcAddr == '0)
      o_operand = '0;
    else if (i_wbWe && (i_wbAddr == i_srcAddr))
      o_operand = i_wbData;
  end

endmodule

// File: rtl/operand_fetch.sv
// Register-file read initiator: latches the instruction, captures forwarded operands, hands them off via valid/ready.
// Optional: OPERAND_FETCH_HOLD_REFRESH_EN lets writebacks refresh held operands while waiting in HOLD.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int width     = 32,
  parameter int addrWidth = 5
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic [31:0]          instr,
  input  logic                 instrValid,
  output logic                 instrReady,
  output logic [addrWidth-1:0] readAddr0,
  output logic [addrWidth-1:0] readAddr1,
  input  logic [width-1:0]     rfData0,
  input  logic [width-1:0]     rfData1,
  input  logic                 wbWe,
  input  logic [addrWidth-1:0] wbAddr,
  input  logic [width-1:0]     wbData,
  output logic [width-1:0]     opA,
  output logic [width-1:0]     opB,
  output logic [width-1:0]     opImm,
  output logic [addrWidth-1:0] opRd,
  output logic [addrWidth-1:0] opRt,
  output logic                 opValid,
  input  logic                 opReady
);

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_instr;
  logic             w_accept;
  logic [width-1:0] w_src0, w_src1, w_fwdA, w_fwdB;
  logic             w_unused;

  assign w_unused   = ^r_instr[31:26];
  assign readAddr0  = r_instr[RS_MSB:RS_LSB];
  assign readAddr1  = r_instr[RT_MSB:RT_LSB];
  assign instrReady = (r_state == IDLE) || ((r_state == HOLD) && opReady);
  assign w_accept   = instrValid && instrReady;

  // In HOLD the held operand stands in for the regfile so the same mux yields the refresh value.
  assign w_src0 = (r_state == HOLD) ? opA : rfData0;
  assign w_src1 = (r_state == HOLD) ? opB : rfData1;

  operand_fwd_mux #(.width(width), .addrWidth(addrWidth)) u_fwd_a (
    .i_srcAddr(readAddr0), .i_wbWe(wbWe), .i_wbAddr(wbAddr), .i_wbData(wbData),
    .i_rfData(w_src0), .o_operand(w_fwdA)
  );

  operand_fwd_mux #(.width(width), .addrWidth(addrWidth)) u_fwd_b (
    .i_srcAddr(readAddr1), .i_wbWe(wbWe), .i_wbAddr(wbAddr), .i_wbData(wbData),
    .i_rfData(w_src1), .o_operand(w_fwdB)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = FETCH;
      FETCH:   w_next = HOLD;
      HOLD:    if (opReady) w_next = w_accept ? FETCH : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_instr <= '0;
      opA     <= '0;
      opB     <= '0;
      opImm   <= '0;
      opRd    <= '0;
      opRt    <= '0;
      opValid <= 1'b0;
    end else begin
      if (w_accept) r_instr <= instr;
      case (r_state)
        FETCH: begin
          opA     <= w_fwdA;
          opB     <= w_fwdB;
          opImm   <= {{(width-IMM_MSB-1){r_instr[IMM_MSB]}}, r_instr[IMM_MSB:0]};
          opRd    <= r_instr[RD_MSB:RD_LSB];
          opRt    <= r_instr[RT_MSB:RT_LSB];
          opValid <= 1'b1;
        end
        HOLD: begin
`ifdef OPERAND_FETCH_HOLD_REFRESH_EN
          opA <= w_fwdA;
          opB <= w_fwdB;
`endif
          if (opReady) opValid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a small behavioural regfile driving the read ports.
module tb_operand_fetch;

  logic        clk, rstN;
  logic [31:0] instr;
  logic        instrValid, instrReady;
  logic [4:0]  readAddr0, readAddr1;
  logic [31:0] rfData0, rfData1;
  logic        wbWe;
  logic [4:0]  wbAddr;
  logic [31:0] wbData;
  logic [31:0] opA, opB, opImm;
  logic [4:0]  opRd, opRt;
  logic        opValid, opReady;

  logic [31:0] rf [32];
  int n_checks = 0;
  int n_fail   = 0;

  assign rfData0 = rf[readAddr0];
  assign rfData1 = rf[readAddr1];

  operand_fetch dut (
    .clk(clk), .rstN(rstN), .instr(instr), .instrValid(instrValid), .instrReady(instrReady),
    .readAddr0(readAddr0), .readAddr1(readAddr1), .rfData0(rfData0), .rfData1(rfData1),
    .wbWe(wbWe), .wbAddr(wbAddr), .wbData(wbData), .opA(opA), .opB(opB), .opImm(opImm),
    .opRd(opRd), .opRt(opRt), .opValid(opValid), .opReady(opReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {6'h23, rs, rt, imm};
  endfunction

  // Called at a negedge with the block ready; returns at the negedge inside FETCH.
  task automatic issue(input logic [31:0] ins);
    instr = ins; instrValid = 1'b1;
    @(negedge clk);
    instrValid = 1'b0;
  endtask

  task automatic consume();
    opReady = 1'b1;
    @(negedge clk);
    opReady = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    #2;
    n_checks++; if (opValid !== 1'b0) begin n_fail++; $display("FAIL reset_opValid got %h want 0", opValid); end
    n_checks++; if (opA !== 32'h0 || opB !== 32'h0 || opImm !== 32'h0) begin n_fail++; $display("FAIL reset_ops got %h %h %h want 0", opA, opB, opImm); end
    n_checks++; if (readAddr0 !== 5'd0 || opRd !== 5'd0) begin n_fail++; $display("FAIL reset_addr got %h %h want 0", readAddr0, opRd); end
    n_checks++; if (instrReady !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %h want 1", instrReady); end
    @(negedge clk); rstN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    issue(mk(5'd3, 5'd4, 16'h2800));
    n_checks++; if (instrReady !== 1'b0) begin n_fail++; $display("FAIL basic_fetch_ready got %h want 0", instrReady); end
    n_checks++; if (opValid !== 1'b0) begin n_fail++; $display("FAIL basic_fetch_valid got %h want 0", opValid); end
    n_checks++; if (readAddr0 !== 5'd3 || readAddr1 !== 5'd4) begin n_fail++; $display("FAIL basic_raddr got %0d %0d want 3 4", readAddr0, readAddr1); end
    @(negedge clk);
    n_checks++; if (opValid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %h want 1", opValid); end
    n_checks++; if (opA !== 32'h11) begin n_fail++; $display("FAIL basic_opA got %h want 11", opA); end
    n_checks++; if (opB !== 32'h22) begin n_fail++; $display("FAIL basic_opB got %h want 22", opB); end
    n_checks++; if (opRd !== 5'd5 || opRt !== 5'd4) begin n_fail++; $display("FAIL basic_rd_rt got %0d %0d want 5 4", opRd, opRt); end
    consume();
    n_checks++; if (opValid !== 1'b0) begin n_fail++; $display("FAIL basic_consumed got %h want 0", opValid); end
  endtask

  task automatic test_forward();
    issue(mk(5'd3, 5'd3, 16'h0));
    wbWe = 1'b1; wbAddr = 5'd3; wbData = 32'hDEAD;
    @(negedge clk);
    wbWe = 1'b0;
    n_checks++; if (opA !== 32'hDEAD || opB !== 32'hDEAD) begin n_fail++; $display("FAIL fwd_same got %h %h want DEAD DEAD", opA, opB); end
    consume();
    issue(mk(5'd0, 5'd4, 16'h0));
    wbWe = 1'b1; wbAddr = 5'd0; wbData = 32'hBEEF;
    @(negedge clk);
    wbWe = 1'b0;
    n_checks++; if (opA !== 32'h0) begin n_fail++; $display("FAIL fwd_zero got %h want 0", opA); end
    n_checks++; if (opB !== 32'h22) begin n_fail++; $display("FAIL fwd_zero_rt got %h want 22", opB); end
    consume();
  endtask

  task automatic test_back_to_back();
    issue(mk(5'd3, 5'd4, 16'h1234));
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (opA !== 32'h11 || opB !== 32'h22 || opImm !== 32'h1234 || opValid !== 1'b1)
        begin n_fail++; $display("FAIL bp_stable[%0d] got %h %h %h %h want 11 22 1234 1", i, opA, opB, opImm, opValid); end
      n_checks++; if (instrReady !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got %h want 0", i, instrReady); end
    end
    opReady = 1'b1; instr = mk(5'd4, 5'd3, 16'h0); instrValid = 1'b1;
    #1;
    n_checks++; if (instrReady !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %h want 1", instrReady); end
    @(negedge clk);
    opReady = 1'b0; instrValid = 1'b0;
    n_checks++; if (opValid !== 1'b0 || readAddr0 !== 5'd4) begin n_fail++; $display("FAIL b2b_gap got %h %0d want 0 4", opValid, readAddr0); end
    @(negedge clk);
    n_checks++; if (opValid !== 1'b1 || opA !== 32'h22 || opB !== 32'h11) begin n_fail++; $display("FAIL b2b_second got %h %h %h want 1 22 11", opValid, opA, opB); end
    consume();
  endtask

  task automatic test_imm();
    issue(mk(5'd1, 5'd2, 16'h8001));
    @(negedge clk);
    n_checks++; if (opImm !== 32'hFFFF8001) begin n_fail++; $display("FAIL imm_neg got %h want FFFF8001", opImm); end
    n_checks++; if (opRd !== 5'd16 || opRt !== 5'd2) begin n_fail++; $display("FAIL imm_neg_rd got %0d %0d want 16 2", opRd, opRt); end
    consume();
    issue(mk(5'd1, 5'd2, 16'h7FFF));
    @(negedge clk);
    n_checks++; if (opImm !== 32'h00007FFF) begin n_fail++; $display("FAIL imm_pos got %h want 00007FFF", opImm); end
    n_checks++; if (opRd !== 5'd15) begin n_fail++; $display("FAIL imm_pos_rd got %0d want 15", opRd); end
    consume();
  endtask

  task automatic test_async_reset();
    issue(mk(5'd3, 5'd4, 16'h0));
    #2 rstN = 1'b0;
    #1;
    n_checks++; if (opValid !== 1'b0 || instrReady !== 1'b1 || readAddr0 !== 5'd0) begin n_fail++; $display("FAIL arst_fetch got %h %h %0d want 0 1 0", opValid, instrReady, readAddr0); end
    @(negedge clk); rstN = 1'b1;
    @(negedge clk);
    issue(mk(5'd3, 5'd4, 16'h0));
    @(negedge clk);
    n_checks++; if (opValid !== 1'b1 || opA !== 32'h11) begin n_fail++; $display("FAIL arst_recover got %h %h want 1 11", opValid, opA); end
    #2 rstN = 1'b0;
    #1;
    n_checks++; if (opValid !== 1'b0 || opA !== 32'h0) begin n_fail++; $display("FAIL arst_hold got %h %h want 0 0", opValid, opA); end
    @(negedge clk); rstN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_hold_refresh();
    logic [31:0] exp_b;
`ifdef OPERAND_FETCH_HOLD_REFRESH_EN
    exp_b = 32'h5;
`else
    exp_b = 32'h22;
`endif
    issue(mk(5'd3, 5'd4, 16'h0));
    @(negedge clk);
    wbWe = 1'b1; wbAddr = 5'd4; wbData = 32'h5;
    @(negedge clk);
    wbWe = 1'b0;
    n_checks++; if (opB !== exp_b) begin n_fail++; $display("FAIL refresh_opB got %h want %h", opB, exp_b); end
    n_checks++; if (opA !== 32'h11 || opValid !== 1'b1) begin n_fail++; $display("FAIL refresh_opA got %h %h want 11 1", opA, opValid); end
    consume();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
    rf[0] = 32'h999;
    rf[3] = 32'h11;
    rf[4] = 32'h22;
    instr = '0; instrValid = 1'b0; opReady = 1'b0;
    wbWe = 1'b0; wbAddr = '0; wbData = '0;
    test_reset();
    test_basic();
    test_forward();
    test_back_to_back();
    test_imm();
    test_async_reset();
    test_hold_refresh();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
